// File: rtl/qrs_extremum_search_if.sv
// Handshake bundle between the QRS algorithm FSM (master) and the extremum search (slave).
// Carries the qualified abs-diff stream, search control and the peak-report outputs.
interface qrs_extremum_search_if #(
  parameter int unsigned DATA_WIDTH = 11
);
  logic                  i_ce;
  logic [DATA_WIDTH-1:0] i_abs_diff;
  logic                  i_abs_diff_valid;
  logic                  i_qrs_search_en;
  logic [DATA_WIDTH-1:0] i_qrs_threshold;
  logic                  i_th_initialised;
  logic                  o_abs_diff_short_valid;
  logic [DATA_WIDTH-1:0] o_abs_diff_short_max;
  logic                  o_extremum_found;
  logic                  o_refractory;

  modport master (
    output i_ce, i_abs_diff, i_abs_diff_valid, i_qrs_search_en, i_qrs_threshold,
           i_th_initialised,
    input  o_abs_diff_short_valid, o_abs_diff_short_max, o_extremum_found, o_refractory
  );

  modport slave (
    input  i_ce, i_abs_diff, i_abs_diff_valid, i_qrs_search_en, i_qrs_threshold,
           i_th_initialised,
    output o_abs_diff_short_valid, o_abs_diff_short_max, o_extremum_found, o_refractory
  );
endinterface

// File: rtl/qrs_extremum_search.sv
// Short-window maximum tracker that confirms an R-peak after PEAK_HOLD samples without a new
// maximum, pulses o_extremum_found once, then ignores REFRACT samples.
module qrs_extremum_search #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned PEAK_HOLD  = 18,
  parameter int unsigned REFRACT    = 72,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic                   i_clk,
  input logic                   i_nrst,
  qrs_extremum_search_if.slave  io_bus
);

  typedef enum logic [2:0] {StTrack, StArmed, StCandidate, StReport, StRefract} state_e;

  localparam logic [CNT_WIDTH-1:0] HoldLast    = CNT_WIDTH'(PEAK_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] RefractLast = CNT_WIDTH'(REFRACT - 1);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_max;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_valid;
  logic                  r_pulse;
  logic                  r_refract;
  logic                  r_th_q;

  logic                  w_s;
  logic [DATA_WIDTH-1:0] w_x;
  logic                  w_gt_max;
  logic                  w_gt_thr;
  logic                  w_th;
  logic                  w_en;

  assign w_s  = io_bus.i_ce & io_bus.i_abs_diff_valid;
  assign w_th = io_bus.i_th_initialised;
  assign w_en = io_bus.i_qrs_search_en;
  // Clamped sample has a zero sign bit, so plain unsigned compares act on the magnitude.
  assign w_x      = io_bus.i_abs_diff[DATA_WIDTH-1] ? '0 : io_bus.i_abs_diff;
  assign w_gt_max = w_x > r_max;
  assign w_gt_thr = w_x > io_bus.i_qrs_threshold;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= StTrack;
      r_max     <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_pulse   <= 1'b0;
      r_refract <= 1'b0;
      r_th_q    <= 1'b0;
    end else begin
      r_th_q  <= w_th;
      r_pulse <= 1'b0;
      if (w_s) r_valid <= 1'b1;
      // Losing threshold initialisation restarts the search from scratch.
      if (r_state != StTrack && !w_th) begin
        r_state   <= StTrack;
        r_max     <= '0;
        r_cnt     <= '0;
        r_refract <= 1'b0;
      end else begin
        case (r_state)
          StTrack: begin
            if (w_th && !r_th_q) begin
              r_state <= StArmed;
              r_max   <= '0;
            end else if (w_s && w_gt_max) begin
              r_max <= w_x;
            end
          end
          StArmed: begin
            if (w_s && w_en && w_gt_thr) begin
              r_state <= StCandidate;
              r_max   <= w_x;
              r_cnt   <= '0;
            end
          end
          StCandidate: begin
            if (!w_en) begin
              r_state <= StArmed;
            end else if (w_s) begin
              if (w_gt_max) begin
                r_max <= w_x;
                r_cnt <= '0;
              end else if (r_cnt == HoldLast) begin
                r_state <= StReport;
                r_pulse <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          StReport: begin
            r_state   <= StRefract;
            r_cnt     <= '0;
            r_refract <= 1'b1;
          end
          StRefract: begin
            if (w_s) begin
              if (r_cnt == RefractLast) begin
                r_state   <= StArmed;
                r_refract <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          default: r_state <= StTrack;
        endcase
      end
    end
  end

  assign io_bus.o_abs_diff_short_valid = r_valid;
  assign io_bus.o_abs_diff_short_max   = r_max;
  assign io_bus.o_extremum_found       = r_pulse;
  assign io_bus.o_refractory           = r_refract;

endmodule

// File: tb/tb_qrs_extremum_search.sv
// Directed bench for qrs_extremum_search: each sample pushes its expected outputs to a
// scoreboard which is popped and compared one time step after the consuming clock edge.
module tb_qrs_extremum_search;

  localparam int unsigned DW = 11;

  typedef struct {
    logic          v;
    logic          p;
    logic [DW-1:0] m;
    logic          r;
    string         tag;
  } exp_t;

  logic clk;
  logic nrst;
  int   errors = 0;
  int   checks = 0;
  logic exp_valid = 1'b0;
  exp_t sb[$];

  qrs_extremum_search_if #(.DATA_WIDTH(DW)) bus ();

  qrs_extremum_search #(
    .DATA_WIDTH(DW),
    .PEAK_HOLD (4),
    .REFRACT   (6),
    .CNT_WIDTH (8)
  ) dut (
    .i_clk (clk),
    .i_nrst(nrst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_abs_diff_short_valid), 32'd0);
    chk({tag, "_max"},   32'(bus.o_abs_diff_short_max),   32'd0);
    chk({tag, "_pulse"}, 32'(bus.o_extremum_found),       32'd0);
    chk({tag, "_refr"},  32'(bus.o_refractory),           32'd0);
  endtask

  // Drive one cycle of input, push expectation, compare after the edge.
  task automatic smp(input logic vld, input int x, input logic ep, input int em,
                     input logic er, input string tag);
    exp_t e;
    exp_t o;
    @(negedge clk);
    bus.i_abs_diff       = x[DW-1:0];
    bus.i_abs_diff_valid = vld;
    if (vld && bus.i_ce) exp_valid = 1'b1;
    e.v   = exp_valid;
    e.p   = ep;
    e.m   = em[DW-1:0];
    e.r   = er;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk({o.tag, "_valid"}, 32'(bus.o_abs_diff_short_valid), 32'(o.v));
    chk({o.tag, "_pulse"}, 32'(bus.o_extremum_found),       32'(o.p));
    chk({o.tag, "_max"},   32'(bus.o_abs_diff_short_max),   32'(o.m));
    chk({o.tag, "_refr"},  32'(bus.o_refractory),           32'(o.r));
    bus.i_abs_diff_valid = 1'b0;
  endtask

  initial begin
    nrst                 = 1'b0;
    bus.i_ce             = 1'b1;
    bus.i_abs_diff       = '0;
    bus.i_abs_diff_valid = 1'b0;
    bus.i_qrs_search_en  = 1'b0;
    bus.i_qrs_threshold  = 11'd100;
    bus.i_th_initialised = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    nrst = 1'b1;

    // T1: tracking before threshold initialisation, clamping and clock-enable gating.
    smp(1'b1, 5,   1'b0, 5,   1'b0, "t1_s5");
    smp(1'b1, -7,  1'b0, 5,   1'b0, "t1_neg");
    smp(1'b1, 300, 1'b0, 300, 1'b0, "t1_s300");
    smp(1'b1, 120, 1'b0, 300, 1'b0, "t1_s120");
    bus.i_ce = 1'b0;
    smp(1'b1, 900, 1'b0, 300, 1'b0, "t1_ce_off");
    bus.i_ce = 1'b1;

    // T2: arm and detect.
    bus.i_th_initialised = 1'b1;
    smp(1'b0, 0,   1'b0, 0,   1'b0, "t2_arm");
    bus.i_qrs_search_en = 1'b1;
    smp(1'b1, 50,  1'b0, 0,   1'b0, "t2_below");
    smp(1'b1, 150, 1'b0, 150, 1'b0, "t2_cand");
    smp(1'b1, 200, 1'b0, 200, 1'b0, "t2_newmax");
    smp(1'b1, 180, 1'b0, 200, 1'b0, "t2_h1");
    smp(1'b1, 170, 1'b0, 200, 1'b0, "t2_h2");
    smp(1'b1, 160, 1'b0, 200, 1'b0, "t2_h3");
    smp(1'b1, 150, 1'b1, 200, 1'b0, "t2_pulse");
    smp(1'b0, 0,   1'b0, 200, 1'b1, "t2_report_end");

    // T3: refractory ignores a large sample and lasts six samples.
    smp(1'b1, 100, 1'b0, 200, 1'b1, "t3_r1");
    smp(1'b1, 500, 1'b0, 200, 1'b1, "t3_r2_big");
    for (int i = 0; i < 3; i++) smp(1'b1, 100, 1'b0, 200, 1'b1, "t3_rmid");
    smp(1'b1, 100, 1'b0, 200, 1'b0, "t3_armed");

    // T4: a tie does not restart the hold count.
    smp(1'b1, 150, 1'b0, 150, 1'b0, "t4_cand");
    smp(1'b1, 200, 1'b0, 200, 1'b0, "t4_max");
    smp(1'b1, 200, 1'b0, 200, 1'b0, "t4_tie");
    smp(1'b1, 190, 1'b0, 200, 1'b0, "t4_h2");
    smp(1'b1, 180, 1'b0, 200, 1'b0, "t4_h3");
    smp(1'b1, 170, 1'b1, 200, 1'b0, "t4_pulse");
    smp(1'b0, 0,   1'b0, 200, 1'b1, "t4_report_end");
    for (int i = 0; i < 6; i++) smp(1'b1, 10, 1'b0, 200, (i < 5), "t4_refr");

    // T5: abort by dropping search enable, then threshold boundary.
    smp(1'b1, 150, 1'b0, 150, 1'b0, "t5_cand");
    smp(1'b1, 200, 1'b0, 200, 1'b0, "t5_max");
    bus.i_qrs_search_en = 1'b0;
    smp(1'b0, 0,   1'b0, 200, 1'b0, "t5_abort");
    bus.i_qrs_search_en = 1'b1;
    for (int i = 0; i < 4; i++) smp(1'b1, 90, 1'b0, 200, 1'b0, "t5_armed90");
    smp(1'b1, 100, 1'b0, 200, 1'b0, "t5_thr_equal");
    smp(1'b1, 101, 1'b0, 101, 1'b0, "t5_thr_exceed");
    smp(1'b1, 50,  1'b0, 101, 1'b0, "t5_hold");

    // T6: asynchronous reset between edges, then threshold loss in refractory.
    @(negedge clk);
    nrst                 = 1'b0;
    bus.i_th_initialised = 1'b0;
    bus.i_qrs_search_en  = 1'b0;
    #1;
    chk_all_zero("t6_async");
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("t6_release_valid", 32'(bus.o_abs_diff_short_valid), 32'd0);
    smp(1'b0, 0,  1'b0, 0,  1'b0, "t6_idle");
    smp(1'b1, 40, 1'b0, 40, 1'b0, "t6_track");
    bus.i_th_initialised = 1'b1;
    smp(1'b0, 0,   1'b0, 0,   1'b0, "t6_arm");
    bus.i_qrs_search_en = 1'b1;
    smp(1'b1, 150, 1'b0, 150, 1'b0, "t6_cand");
    smp(1'b1, 140, 1'b0, 150, 1'b0, "t6_h1");
    smp(1'b1, 130, 1'b0, 150, 1'b0, "t6_h2");
    smp(1'b1, 120, 1'b0, 150, 1'b0, "t6_h3");
    smp(1'b1, 110, 1'b1, 150, 1'b0, "t6_pulse");
    smp(1'b0, 0,   1'b0, 150, 1'b1, "t6_report_end");
    smp(1'b1, 10,  1'b0, 150, 1'b1, "t6_refr");
    bus.i_th_initialised = 1'b0;
    smp(1'b0, 0,   1'b0, 0,   1'b0, "t6_th_drop");
    smp(1'b1, 60,  1'b0, 60,  1'b0, "t6_retrack");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
